// File: rtl/otf_converter_r4_pkg.sv
// online_r4_defs: shared radix-4 online digit constants and converter FSM states
package online_r4_defs;
  localparam int RADIX = 4;
  localparam int DIGIT_W = 3;
  localparam int DIG_MIN = -3;
  localparam int DIG_MAX = 3;
  localparam int DIG_ILLEGAL = -4;
  typedef enum logic [1:0] {IDLE = 2'd0, SKIPPING = 2'd1, CONV = 2'd2} state_t;
endpackage

// File: rtl/otf_converter_r4_step.sv
// otf_step_r4: one on-the-fly conversion step (Q, QM, d) -> (Q', QM', err)
module otf_step_r4
  import online_r4_defs::*;
#(
  parameter int W = 15,
  parameter int C = DIGIT_W
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [C-1:0] d,
  output logic [W-1:0] q_n,
  output logic [W-1:0] qm_n,
  output logic         err
);
  logic [W-1:0] q4, qm4, dx;
  logic pos, neg;
  always_comb begin
    q4   = q << 2;
    qm4  = qm << 2;
    dx   = W'($signed(d));
    neg  = d[C-1];
    pos  = !neg && (|d);
    // negative digits borrow from QM so no carry ever ripples through Q
    q_n  = pos ? q4 + dx : neg ? qm4 + dx + W'(RADIX) : q4;
    qm_n = pos ? q4 + dx - W'(1) : qm4 + dx + W'(RADIX - 1);
    err  = d == C'(DIG_ILLEGAL);
  end
endmodule

// File: rtl/otf_converter_r4.sv
// otf_converter_r4: MSD-first signed radix-4 digit stream to two's-complement word
module otf_converter_r4
  import online_r4_defs::*;
#(
  parameter int C = 3,
  parameter int N = 7,
  parameter int SKIP = 0,
  localparam int W = 2 * N + 1,
  localparam int CW = $clog2(N + SKIP + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                start,
  input  logic [C-1:0]        zi,
  output logic signed [W-1:0] z,
  output logic                valid,
  output logic                busy,
  output logic                dig_err
);
  state_t state_q, state_d;
  logic [W-1:0] q_q, q_d, qm_q, qm_d, z_q, z_d, q_n, qm_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, busy_q, busy_d, err_q, err_d, step_err, skip_last, conv_last;

  otf_step_r4 #(.W(W), .C(C)) u_step (
    .q(q_q), .qm(qm_q), .d(zi), .q_n(q_n), .qm_n(qm_n), .err(step_err)
  );

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    qm_d      = qm_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
    skip_last = cnt_q == CW'(SKIP - 1);
    conv_last = cnt_q == CW'(N - 1);
    if (start) begin
      state_d = SKIP > 0 ? SKIPPING : CONV;
      q_d     = '0;
      qm_d    = '1;
      cnt_d   = '0;
      err_d   = 1'b0;
      busy_d  = 1'b1;
    end else if (en && state_q == SKIPPING) begin
      cnt_d   = skip_last ? '0 : cnt_q + CW'(1);
      state_d = skip_last ? CONV : SKIPPING;
    end else if (en && state_q == CONV) begin
      q_d     = q_n;
      qm_d    = qm_n;
      err_d   = err_q | step_err;
      cnt_d   = cnt_q + CW'(1);
      state_d = conv_last ? IDLE : CONV;
      z_d     = conv_last ? q_n : z_q;
      valid_d = conv_last;
      busy_d  = !conv_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign z       = z_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign dig_err = err_q;
endmodule
